// File: rtl/cla_pkg.sv
// Shared constants and width legality check for the carry-lookahead adder.
package cla_pkg;

    localparam int GROUP_W = 4;
    localparam int MAX_W   = 64;

    function automatic bit width_ok(input int w);
        return (w >= GROUP_W) && (w <= MAX_W) && ((w % GROUP_W) == 0);
    endfunction

endpackage

// File: rtl/cla4_block.sv
// One 4-bit lookahead group: fully expanded internal carries, sum bits, and group G/P.
module cla4_block
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] p,
    input  logic [GROUP_W-1:0] g,
    input  logic               ci,
    output logic [GROUP_W-1:0] s,
    output logic               gg,
    output logic               pg
);

    logic c1;
    logic c2;
    logic c3;

    // Every carry is a flat sum of products of p/g/ci, never chained through c1/c2.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s  = p ^ {c3, c2, c1, ci};

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign pg = &p;

endmodule

// File: rtl/carry_lookahead_adder.sv
// Registered two-level carry-lookahead adder, one result per cycle.
// Optional signed overflow output ovf is enabled with macro CLA_OVERFLOW_EN.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef CLA_OVERFLOW_EN
   ,output logic             ovf
`endif
);

    localparam int NGRP = WIDTH / GROUP_W;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("carry_lookahead_adder: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_raw;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic             acc;
    logic             term_p;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        cla4_block u_blk (
            .p  (p[j*GROUP_W +: GROUP_W]),
            .g  (g[j*GROUP_W +: GROUP_W]),
            .ci (grp_c[j]),
            .s  (sum_raw[j*GROUP_W +: GROUP_W]),
            .gg (grp_g[j]),
            .pg (grp_p[j])
        );
    end

    // Second lookahead level: each group carry is expanded over all lower groups and cin.
    always_comb begin
        grp_c    = '0;
        acc      = 1'b0;
        term_p   = 1'b1;
        grp_c[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            acc    = 1'b0;
            term_p = 1'b1;
            for (int k = j; k >= 0; k--) begin
                acc    = acc | (term_p & grp_g[k]);
                term_p = term_p & grp_p[k];
            end
            grp_c[j+1] = acc | (term_p & cin);
        end
    end

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             vld_d, vld_q;

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        vld_d  = in_valid;
        if (in_valid) begin
            sum_d  = sum_raw;
            cout_d = grp_c[NGRP];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = vld_q;

`ifdef CLA_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit, since s = p ^ c.
    always_comb begin
        ovf_d = ovf_q;
        if (in_valid) begin
            ovf_d = grp_c[NGRP] ^ (p[WIDTH-1] ^ sum_raw[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Self-checking bench: directed 4-bit vectors, reset corner cases, and random 16-bit run.
module tb_carry_lookahead_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        v4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        c4 = 1'b0;
    logic [3:0]  sum4;
    logic        cout4;
    logic        ov4;

    logic        v16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        c16 = 1'b0;
    logic [15:0] sum16;
    logic        cout16;
    logic        ov16;
`ifdef CLA_OVERFLOW_EN
    logic        ovf16;
    logic        ovf4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .cin       (c4),
        .sum       (sum4),
        .cout      (cout4),
        .out_valid (ov4)
`ifdef CLA_OVERFLOW_EN
       ,.ovf       (ovf4)
`endif
    );

    carry_lookahead_adder #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v16),
        .a         (a16),
        .b         (b16),
        .cin       (c16),
        .sum       (sum16),
        .cout      (cout16),
        .out_valid (ov16)
`ifdef CLA_OVERFLOW_EN
       ,.ovf       (ovf16)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[7];

    logic [16:0] full;
    logic [15:0] m_sum;
    logic        m_cout;
    logic        m_ovf;
    int          s_signed;

    initial begin
        vecs[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        vecs[1] = '{4'h1, 4'h1, 1'b1, 4'h3, 1'b0};
        vecs[2] = '{4'h6, 4'hD, 1'b1, 4'h4, 1'b1};
        vecs[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        vecs[4] = '{4'hC, 4'h5, 1'b0, 4'h1, 1'b1};
        vecs[5] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        vecs[6] = '{4'h8, 4'h7, 1'b0, 4'hF, 1'b0};

        #3;
        check("reset_sum4", sum4, 0);
        check("reset_cout4", cout4, 0);
        check("reset_valid4", ov4, 0);
        check("reset_valid16", ov16, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Back-to-back directed vectors, one result per cycle.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a4 = vecs[i].a; b4 = vecs[i].b; c4 = vecs[i].cin; v4 = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_sum", i), sum4, vecs[i].exp_sum);
            check($sformatf("vec%0d_cout", i), cout4, vecs[i].exp_cout);
            check($sformatf("vec%0d_valid", i), ov4, 1);
        end

        // Idle cycle: outputs hold, out_valid drops.
        @(negedge clk);
        v4 = 1'b0; a4 = 4'h9; b4 = 4'h9; c4 = 1'b1;
        @(posedge clk); #1;
        check("hold_sum", sum4, 4'hF);
        check("hold_cout", cout4, 0);
        check("hold_valid", ov4, 0);

        // Asynchronous reset in the middle of a stream.
        @(negedge clk);
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; v4 = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_sum", sum4, 4'h7);
        #1 rst = 1'b1;
        #1;
        check("async_rst_sum", sum4, 0);
        check("async_rst_cout", cout4, 0);
        check("async_rst_valid", ov4, 0);
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h9; c4 = 1'b0;
        @(posedge clk); #1;
        check("in_rst_sum", sum4, 0);
        check("in_rst_valid", ov4, 0);
        #2 rst = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", ov4, 0);
        check("post_rst_sum", sum4, 0);
        check("post_rst_cout", cout4, 0);
        @(negedge clk);
        a4 = 4'h5; b4 = 4'h6; c4 = 1'b1; v4 = 1'b1;
        @(posedge clk); #1;
        check("first_after_rst_sum", sum4, 4'hC);
        check("first_after_rst_cout", cout4, 0);
        check("first_after_rst_valid", ov4, 1);
        @(negedge clk);
        v4 = 1'b0;

        // 16-bit directed signed-overflow case.
        @(negedge clk);
        a16 = 16'h7FFF; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
        @(posedge clk); #1;
        check("w16_sum", sum16, 16'h8000);
        check("w16_cout", cout16, 0);
        check("w16_valid", ov16, 1);
`ifdef CLA_OVERFLOW_EN
        check("w16_ovf", ovf16, 1);
`endif
        m_sum = 16'h8000; m_cout = 1'b0; m_ovf = 1'b1;

        // Random run against a + b + cin with hold on idle cycles.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            v16 = ($urandom_range(0, 3) != 0);
            a16 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            b16 = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
            c16 = 1'($urandom);
            if (v16) begin
                full     = {1'b0, a16} + {1'b0, b16} + 17'(c16);
                m_sum    = full[15:0];
                m_cout   = full[16];
                s_signed = int'($signed(a16)) + int'($signed(b16)) + int'(c16);
                m_ovf    = (s_signed > 32767) || (s_signed < -32768);
            end
            @(posedge clk); #1;
            check("rnd_valid", ov16, v16);
            check("rnd_sum", sum16, m_sum);
            check("rnd_cout", cout16, m_cout);
`ifdef CLA_OVERFLOW_EN
            check("rnd_ovf", ovf16, m_ovf);
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
